// File: rtl/ripple_count_sampler.sv
// Brings a free-running ripple-counter value into the clk domain and accepts it once it is stable.
// Accepted values drive wrap/match flags, and a small FSM serves snapshot requests with a timeout.
module ripple_count_sampler #(
   parameter int N             = 4,
   parameter int STABLE_CYCLES = 2,
   parameter int TIMEOUT       = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] cnt_in,
   input  logic [N-1:0] match_val,
   input  logic         sample_req,
   output logic         busy,
   output logic         snap_valid,
   output logic [N-1:0] snap_value,
   output logic         timeout_err,
   output logic [N-1:0] stable_val,
   output logic         match,
   output logic         wrap,
   output logic [7:0]   wrap_count
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   logic [N-1:0]  s1_q, s2_q, s2d_q;
   logic [SW-1:0] stab_q, stab_d;
   logic          have_q, have_d;
   logic [N-1:0]  stable_q, stable_d;
   logic          match_q, match_d;
   logic          wrap_q, wrap_d;
   logic [7:0]    wrap_cnt_q, wrap_cnt_d;
   state_t        state_q, state_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          snap_valid_q, snap_valid_d;
   logic [N-1:0]  snap_value_q, snap_value_d;
   logic          timeout_q, timeout_d;
   logic          acc;

   always_comb begin
      // NOTE: every signal gets its default first so no path through the block infers a latch.
      stab_d       = stab_q;
      have_d       = have_q;
      stable_d     = stable_q;
      match_d      = 1'b0;
      wrap_d       = 1'b0;
      wrap_cnt_d   = wrap_cnt_q;
      state_d      = state_q;
      tmo_d        = tmo_q;
      snap_valid_d = 1'b0;
      snap_value_d = snap_value_q;
      timeout_d    = 1'b0;

      if (s2_q != s2d_q)
         stab_d = '0;
      else if (stab_q != STAB_MAX)
         stab_d = stab_q + 1'b1;

      // Accept only on the transition into saturation, so a held value is taken once.
      acc = (stab_d == STAB_MAX) && (stab_q != STAB_MAX);

      if (acc) begin
         stable_d = s2_q;
         have_d   = 1'b1;
         wrap_d   = have_q && (s2_q < stable_q);
         match_d  = (s2_q == match_val) && (!have_q || (s2_q != stable_q));
         if (wrap_d && (wrap_cnt_q != 8'hFF))
            wrap_cnt_d = wrap_cnt_q + 8'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (sample_req) begin
               if (stab_q == STAB_MAX) begin
                  snap_value_d = s2_q;
                  snap_valid_d = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  tmo_d   = '0;
               end
            end
         end
         S_WAIT: begin
            if (acc) begin
               snap_value_d = s2_q;
               snap_valid_d = 1'b1;
               state_d      = S_IDLE;
            end else if (tmo_q == TMO_LAST) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q         <= '0;
         s2_q         <= '0;
         s2d_q        <= '0;
         stab_q       <= '0;
         have_q       <= 1'b0;
         stable_q     <= '0;
         match_q      <= 1'b0;
         wrap_q       <= 1'b0;
         wrap_cnt_q   <= '0;
         state_q      <= S_IDLE;
         tmo_q        <= '0;
         snap_valid_q <= 1'b0;
         snap_value_q <= '0;
         timeout_q    <= 1'b0;
      end else begin
         s1_q         <= cnt_in;
         s2_q         <= s1_q;
         s2d_q        <= s2_q;
         stab_q       <= stab_d;
         have_q       <= have_d;
         stable_q     <= stable_d;
         match_q      <= match_d;
         wrap_q       <= wrap_d;
         wrap_cnt_q   <= wrap_cnt_d;
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         snap_valid_q <= snap_valid_d;
         snap_value_q <= snap_value_d;
         timeout_q    <= timeout_d;
      end
   end

   assign busy        = (state_q == S_WAIT);
   assign snap_valid  = snap_valid_q;
   assign snap_value  = snap_value_q;
   assign timeout_err = timeout_q;
   assign stable_val  = stable_q;
   assign match       = match_q;
   assign wrap        = wrap_q;
   assign wrap_count  = wrap_cnt_q;

endmodule
